codifica_hamming_serial: RTL and testbench
==========================================

// Module: codifica_hamming_serial
// PURPOSE
//  Upstream stage of the Hamming(15,11) corrector: accepts 11-bit data words over valid/ready,
//  encodes each into a 15-bit codeword and shifts it onto a 1-bit serial link, one bit per clk.
//  The receiver deserialises the link and feeds the corrector. Codeword layout matches the corrector:
//  parity at indices 0,1,3,7; data d[0..10] at indices 2,4,5,6,8,9,10,11,12,13,14.
// PARAMETERS
//  LSB_FIRST   1  1: transmit codeword index 0 first; 0: index 14 first
//  IDLE_LEVEL  0  serial_out value when no frame is being sent
//  GAP_CYCLES  0  idle cycles forced after each frame (0..15)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   synchronous reset, active-low
//  dado         in   11  data word to encode
//  dado_valid   in   1   dado is valid
//  dado_ready   out  1   block can accept dado this cycle
//  serial_out   out  1   serial codeword bit
//  frame_start  out  1   high while serial_out carries the first bit of a frame
//  busy         out  1   high in SHIFT or GAP
//  codeword     out  15  registered codeword of frame in progress (debug/loopback)
//  inj_pos      in   4   [ERR_INJECT_EN only] error position 1..15, 0 = none
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, serial_out=IDLE_LEVEL, frame_start=0, busy=0,
//   codeword=0, bit counter=0; dado_ready=0 while rst_n=0, 1 the cycle after release.
//  Parity (index form): c0=^{c2,c4,c6,c8,c10,c12,c14}; c1=^{c2,c5,c6,c9,c10,c13,c14};
//   c3=^{c4,c5,c6,c11,c12,c13,c14}; c7=^{c8..c14}. Even parity; all-zero syndrome at receiver.
//  FSM IDLE -> SHIFT -> (GAP if GAP_CYCLES>0) -> IDLE.
//   IDLE: dado_ready=1 (combinational from state). On dado_valid&&dado_ready: register codeword,
//    go SHIFT. dado ignored when dado_valid=0.
//   SHIFT: 15 cycles, counter 0..14; serial_out=codeword[cnt] (LSB_FIRST=1) or codeword[14-cnt].
//    frame_start=1 only when cnt==0. dado_ready=0; dado_valid ignored, no buffering.
//   After cnt==14: GAP for GAP_CYCLES cycles (serial_out=IDLE_LEVEL), else straight to IDLE.
//  Latency: first bit on serial_out the cycle after acceptance; serial_out, frame_start registered.
//  Throughput: one word per 16+GAP_CYCLES cycles.
//  Reset mid-frame aborts the frame immediately; no partial frame resumes.
//  Counter never exceeds 14; GAP counter width is 4 bits.
// CONFIGURATION
//  ERR_INJECT_EN defined: inj_pos port exists; sampled at acceptance; if 1..15,
//   bit index inj_pos-1 of the registered codeword is inverted after parity generation
//   (codeword output shows the corrupted word). inj_pos=0 sends a clean word.
//  ERR_INJECT_EN undefined: no inj_pos port; codeword always clean.
// STRUCTURE
//  Shared package: codeword/data widths (15/11), parity index list {0,1,3,7},
//   data-to-codeword index map, FSM state encoding (IDLE/SHIFT/GAP).
//  One sub-module: hamming_enc_15_11 (combinational 11->15 encoder), reusable by the bench
//   golden model. Top holds FSM, counters, shift output.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles mid-frame -> serial_out=IDLE_LEVEL, busy=0, dado_ready=1 after release.
//  2 dado=11'h000 -> codeword 15'h0000; 15 serial zeros; frame_start only on first bit.
//  3 dado=11'h001 -> codeword 15'h0007; dado=11'h400 -> 15'h408B; LSB_FIRST=1 bit order checked.
//  4 dado=11'h7FF -> 15'h7FFF; LSB_FIRST=0 sends index 14 first.
//  5 Back-to-back valid held high, GAP_CYCLES=3 -> frames start every 19 cycles; dado_ready low
//    in SHIFT/GAP; words not dropped or duplicated.
//  6 ERR_INJECT_EN: dado=11'h001, inj_pos=5 -> codeword 15'h0017; loopback through corrector
//    returns 11'h001.

Source files
------------

// File: rtl/codifica_hamming_serial_pkg.sv
// rtl/codifica_hamming_serial_pkg.sv - shared widths, index maps and state encoding for the Hamming(15,11) serialiser
package codifica_hamming_serial_pkg;

    localparam int CW_W     = 15;
    localparam int DATA_W   = 11;
    localparam int N_PARITY = 4;

    // Parity bits sit at power-of-two positions (1-based), i.e. indices 0,1,3,7.
    localparam logic [3:0] PARITY_IDX [N_PARITY] = '{4'd0, 4'd1, 4'd3, 4'd7};
    localparam logic [3:0] DATA_IDX   [DATA_W]   = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
                                                     4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // One-hot flip mask for a 1-based error position; 0 means no corruption.
    function automatic logic [CW_W-1:0] inj_mask(input logic [3:0] pos);
        return (pos == 4'd0) ? '0 : (CW_W'(1) << (pos - 4'd1));
    endfunction

endpackage

// File: rtl/codifica_hamming_serial_if.sv
// rtl/codifica_hamming_serial_if.sv - data handshake and serial link bundle (ERR_INJECT_EN adds inj_pos)
interface codifica_hamming_serial_if;
    import codifica_hamming_serial_pkg::*;

    logic [DATA_W-1:0] dado;
    logic              dado_valid;
    logic              dado_ready;
    logic              serial_out;
    logic              frame_start;
    logic              busy;
    logic [CW_W-1:0]   codeword;
`ifdef ERR_INJECT_EN
    logic [3:0]        inj_pos;
`endif

    modport master (
`ifdef ERR_INJECT_EN
        output inj_pos,
`endif
        output dado, dado_valid,
        input  dado_ready, serial_out, frame_start, busy, codeword
    );

    modport slave (
`ifdef ERR_INJECT_EN
        input  inj_pos,
`endif
        input  dado, dado_valid,
        output dado_ready, serial_out, frame_start, busy, codeword
    );

endinterface

// File: rtl/codifica_hamming_serial_enc.sv
// rtl/codifica_hamming_serial_enc.sv - combinational Hamming(15,11) encoder, even parity
module hamming_enc_15_11
    import codifica_hamming_serial_pkg::*;
(
    input  logic [DATA_W-1:0] dado,
    output logic [CW_W-1:0]   codeword
);

    always_comb begin
        codeword = '0;
        for (int i = 0; i < DATA_W; i++) begin
            codeword[DATA_IDX[i]] = dado[i];
        end
        // Parity k covers every 1-based position with bit k set; other parity slots are never covered.
        for (int k = 0; k < N_PARITY; k++) begin
            logic p;
            p = 1'b0;
            for (int j = 0; j < CW_W; j++) begin
                if (((j + 1) & (1 << k)) != 0) begin
                    p = p ^ codeword[j];
                end
            end
            codeword[PARITY_IDX[k]] = p;
        end
    end

endmodule

// File: rtl/codifica_hamming_serial.sv
// rtl/codifica_hamming_serial.sv - Hamming(15,11) encoder with 1-bit serial output; ERR_INJECT_EN enables inj_pos error injection
module codifica_hamming_serial
    import codifica_hamming_serial_pkg::*;
#(
    parameter int LSB_FIRST  = 1,
    parameter int IDLE_LEVEL = 0,
    parameter int GAP_CYCLES = 0
) (
    input logic                       clk,
    input logic                       rst_n,
    codifica_hamming_serial_if.slave  bus
);

    localparam logic       IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic [3:0] LAST_BIT = 4'd14;
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t          state;
    logic [3:0]      cnt;
    logic [3:0]      gap_cnt;
    logic [CW_W-1:0] enc_word;
    logic [CW_W-1:0] new_word;
    logic [CW_W-1:0] cw_q;
    logic            ser_q;
    logic            fs_q;
    logic            busy_q;

    hamming_enc_15_11 u_enc (
        .dado     (bus.dado),
        .codeword (enc_word)
    );

`ifdef ERR_INJECT_EN
    assign new_word = enc_word ^ inj_mask(bus.inj_pos);
`else
    assign new_word = enc_word;
`endif

    function automatic logic pick(input logic [CW_W-1:0] cw, input logic [3:0] idx);
        logic [3:0] i;
        i = (LSB_FIRST != 0) ? idx : (LAST_BIT - idx);
        return cw[i];
    endfunction

    assign bus.dado_ready  = rst_n && (state == ST_IDLE);
    assign bus.serial_out  = ser_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.codeword    = cw_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            gap_cnt <= 4'd0;
            cw_q    <= '0;
            ser_q   <= IDLE_BIT;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // First bit is launched from the freshly encoded word so it appears next cycle.
                    if (bus.dado_valid) begin
                        cw_q   <= new_word;
                        cnt    <= 4'd0;
                        ser_q  <= pick(new_word, 4'd0);
                        fs_q   <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    fs_q <= 1'b0;
                    if (cnt == LAST_BIT) begin
                        cnt   <= 4'd0;
                        ser_q <= IDLE_BIT;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= 4'd0;
                            state   <= ST_GAP;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        cnt   <= cnt + 4'd1;
                        ser_q <= pick(cw_q, cnt + 4'd1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 4'd0;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    ser_q  <= IDLE_BIT;
                    fs_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codifica_hamming_serial.sv
// tb/tb_codifica_hamming_serial.sv - randomized bench with a timeline model for two parameterisations
module tb_codifica_hamming_serial;
    import codifica_hamming_serial_pkg::*;

    localparam int P_LSB  [2] = '{1, 0};
    localparam int P_IDLE [2] = '{0, 1};
    localparam int P_GAP  [2] = '{0, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    codifica_hamming_serial_if if0 ();
    codifica_hamming_serial_if if1 ();

    codifica_hamming_serial #(.LSB_FIRST(1), .IDLE_LEVEL(0), .GAP_CYCLES(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (if0.slave)
    );
    codifica_hamming_serial #(.LSB_FIRST(0), .IDLE_LEVEL(1), .GAP_CYCLES(3)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1.slave)
    );

    logic [10:0] dado_d  [2];
    logic        valid_d [2];
    logic [3:0]  inj_d   [2];
    logic        rdy [2], ser [2], fs [2], bsy [2];
    logic [14:0] cwo [2];

    assign if0.dado = dado_d[0];  assign if0.dado_valid = valid_d[0];
    assign if1.dado = dado_d[1];  assign if1.dado_valid = valid_d[1];
`ifdef ERR_INJECT_EN
    assign if0.inj_pos = inj_d[0];
    assign if1.inj_pos = inj_d[1];
`endif
    assign rdy[0] = if0.dado_ready;  assign rdy[1] = if1.dado_ready;
    assign ser[0] = if0.serial_out;  assign ser[1] = if1.serial_out;
    assign fs[0]  = if0.frame_start; assign fs[1]  = if1.frame_start;
    assign bsy[0] = if0.busy;        assign bsy[1] = if1.busy;
    assign cwo[0] = if0.codeword;    assign cwo[1] = if1.codeword;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
        end
    endtask

    // Reference encoder written straight from the parity equations.
    function automatic logic [14:0] enc_model(input logic [10:0] d);
        logic [14:0] c;
        int map [11];
        map = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
        c = '0;
        for (int i = 0; i < 11; i++) c[map[i]] = d[i];
        c[0] = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14]};
        c[1] = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14]};
        c[3] = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14]};
        c[7] = ^c[14:8];
        return c;
    endfunction

    function automatic logic [10:0] dec_model(input logic [14:0] cw);
        int syn;
        int map [11];
        logic [14:0] c;
        logic [10:0] d;
        map = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
        c = cw;
        syn = 0;
        for (int j = 0; j < 15; j++) if (c[j]) syn = syn ^ (j + 1);
        if (syn != 0) c[syn - 1] = ~c[syn - 1];
        for (int i = 0; i < 11; i++) d[i] = c[map[i]];
        return d;
    endfunction

    // Timeline model: phase -1 = idle, 0..14 = bit on the wire, 15.. = gap.
    int          phase  [2];
    logic [14:0] cw_exp [2];
    logic [10:0] wl [2][128];
    logic [3:0]  wi [2][128];
    int head [2], tail [2];
    int rst_hold = 3;
    bit b2b = 0;
    bit per_on = 0;
    int last_fs [2];
    int cyc = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            phase[d] = -1; cw_exp[d] = '0; head[d] = 0; tail[d] = 0; last_fs[d] = -1;
            dado_d[d] = '0; valid_d[d] = 1'b0; inj_d[d] = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                phase[d] = -1;
                cw_exp[d] = '0;
            end else if (phase[d] < 0) begin
                if (valid_d[d]) begin
                    cw_exp[d] = enc_model(dado_d[d]);
`ifdef ERR_INJECT_EN
                    if (inj_d[d] != 0) cw_exp[d][inj_d[d] - 1] = ~cw_exp[d][inj_d[d] - 1];
`endif
                    phase[d] = 0;
                    head[d]++;
                end
            end else begin
                phase[d]++;
                if (phase[d] == 15 + P_GAP[d]) phase[d] = -1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic exp_ser;
            int idx;
            if (phase[d] >= 0 && phase[d] <= 14) begin
                idx = (P_LSB[d] != 0) ? phase[d] : 14 - phase[d];
                exp_ser = cw_exp[d][idx];
            end else begin
                exp_ser = (P_IDLE[d] != 0);
            end
            chk("ready", d, 32'(rdy[d]), 32'(rst_n && phase[d] < 0));
            chk("busy", d, 32'(bsy[d]), 32'(phase[d] >= 0));
            chk("serial", d, 32'(ser[d]), 32'(exp_ser));
            chk("frame_start", d, 32'(fs[d]), 32'(phase[d] == 0));
            if (phase[d] >= 0 || !rst_n) chk("codeword", d, 32'(cwo[d]), 32'(cw_exp[d]));
            if (per_on && fs[d]) begin
                if (last_fs[d] >= 0) chk("period", d, 32'(cyc - last_fs[d]), 32'(16 + P_GAP[d]));
                last_fs[d] = cyc;
            end
        end
        rst_n = (rst_hold == 0);
        if (rst_hold > 0) rst_hold--;
        for (int d = 0; d < 2; d++) begin
            if (head[d] < tail[d]) begin
                dado_d[d]  = wl[d][head[d]];
                inj_d[d]   = wi[d][head[d]];
                valid_d[d] = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
            end else begin
                dado_d[d]  = 11'($urandom);
                inj_d[d]   = 4'($urandom);
                valid_d[d] = 1'b0;
            end
        end
    end

    task automatic push(input logic [10:0] w, input logic [3:0] inj);
        for (int d = 0; d < 2; d++) begin
            wl[d][tail[d]] = w;
            wi[d][tail[d]] = inj;
            tail[d]++;
        end
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (!(head[0] == tail[0] && head[1] == tail[1] && phase[0] < 0 && phase[1] < 0
                 && rst_hold == 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL drain_%s got=timeout want=idle", nm);
        end
    endtask

    logic [3:0] inj_r;

    initial begin
        chk("enc_000", 0, 32'(enc_model(11'h000)), 32'h0000);
        chk("enc_001", 0, 32'(enc_model(11'h001)), 32'h0007);
        chk("enc_400", 0, 32'(enc_model(11'h400)), 32'h408B);
        chk("enc_7ff", 0, 32'(enc_model(11'h7FF)), 32'h7FFF);
`ifdef ERR_INJECT_EN
        chk("inj5", 0, 32'(enc_model(11'h001) ^ 15'h0010), 32'h0017);
        chk("loopback", 0, 32'(dec_model(15'h0017)), 32'h001);
`else
        chk("dec_408b", 0, 32'(dec_model(15'h408B ^ 15'h0100)), 32'h400);
`endif
        repeat (6) @(posedge clk);

        b2b = 1;
        push(11'h000, 4'd0);
        push(11'h001, 4'd0);
        push(11'h400, 4'd0);
        push(11'h7FF, 4'd0);
`ifdef ERR_INJECT_EN
        push(11'h001, 4'd5);
`endif
        wait_drain("directed");

        push(11'h5A5, 4'd0);
        begin
            int n = 0;
            while (phase[0] != 5 && n < 200) begin @(posedge clk); n++; end
            total++;
            if (n >= 200) begin bad++; $display("FAIL midframe got=timeout want=phase5"); end
        end
        rst_hold = 3;
        repeat (6) @(posedge clk);
        wait_drain("reset");

        b2b = 0;
        for (int i = 0; i < 30; i++) begin
`ifdef ERR_INJECT_EN
            inj_r = 4'($urandom_range(0, 15));
`else
            inj_r = 4'd0;
`endif
            push(11'($urandom), inj_r);
        end
        wait_drain("random");

        b2b = 1;
        per_on = 1;
        for (int i = 0; i < 6; i++) push(11'($urandom), 4'd0);
        wait_drain("b2b");
        per_on = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
